// File: rtl/bus_arbiter_mc.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter_mc
//  Purpose  : N-master arbiter/controller between the caches and the single
//             AXI interface controller. Latches pulsed requests, arbitrates
//             with fixed or round-robin priority, issues one line transaction
//             downstream at a time, returns data/ready to the winner and
//             times out transactions the interface never completes.
//  Ports    : clk, rst_n (sync, active-low)
//             m_req_i/m_rw_i/m_addr_i/m_wdata_i   per-master request side
//             m_ready_o/m_err_o/m_rdata_o         per-master response side
//             stall_i                             blocks new grants only
//             bc_valid_req_o/bc_rw_o/bc_addr_o/bc_data_o  downstream request
//             axi_data_i/axi_rd_over_i/axi_wr_over_i      downstream completion
//             busy_o                              high whenever not IDLE
//  Revision : 1.0  initial release
// ============================================================================
module bus_arbiter_mc #(
    parameter int NUM_M   = 3,
    parameter int AW      = 32,
    parameter int DW      = 128,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_M-1:0]    m_req_i,
    input  logic [NUM_M-1:0]    m_rw_i,
    input  logic [NUM_M*AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0] m_wdata_i,
    output logic [NUM_M-1:0]    m_ready_o,
    output logic [NUM_M-1:0]    m_err_o,
    output logic [DW-1:0]       m_rdata_o,
    input  logic                stall_i,
    output logic                bc_valid_req_o,
    output logic                bc_rw_o,
    output logic [AW-1:0]       bc_addr_o,
    output logic [DW-1:0]       bc_data_o,
    input  logic [DW-1:0]       axi_data_i,
    input  logic                axi_rd_over_i,
    input  logic                axi_wr_over_i,
    output logic                busy_o
);

    localparam int IW = $clog2(NUM_M);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [NUM_M-1:0] pending;
    logic [NUM_M-1:0] req_vec;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    ptr_mod;
    logic [IW-1:0]    win_fixed;
    logic [IW-1:0]    win_rr;
    logic             rr_found;
    logic [IW-1:0]    win_sel;
    logic [IW-1:0]    winner;
    logic [NUM_M-1:0] win_onehot;
    logic [CW-1:0]    to_cnt;
    logic             over_hit;
    logic             grant;
    logic             done_ok;
    logic             done_to;
    logic             cnt_inc;
    logic             err_q;

    // A pulse arriving in the same cycle as the grant decision is honoured
    // without waiting for it to land in the pending register.
    assign req_vec    = pending | m_req_i;
    assign win_onehot = NUM_M'(1) << winner;
    // Only the completion matching the outstanding direction counts.
    assign over_hit   = bc_rw_o ? axi_rd_over_i : axi_wr_over_i;

    // Fixed priority: lowest index wins (loop runs high to low so the
    // lowest requester is the last assignment).
    always_comb begin
        win_fixed = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (req_vec[i]) win_fixed = IW'(i);
        end
    end

    // Round robin: first requester after the pointer, modulo NUM_M. Pointer
    // codes at or above NUM_M fold back into range first.
    always_comb begin
        if ({1'b0, rr_ptr} >= (IW+1)'(NUM_M)) begin
            ptr_mod = IW'({1'b0, rr_ptr} - (IW+1)'(NUM_M));
        end else begin
            ptr_mod = rr_ptr;
        end
        win_rr   = '0;
        rr_found = 1'b0;
        for (int j = 1; j <= NUM_M; j++) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (!rr_found && req_vec[i] && (i == (int'(ptr_mod) + j) % NUM_M)) begin
                    rr_found = 1'b1;
                    win_rr   = IW'(i);
                end
            end
        end
    end

    assign win_sel = (RR_MODE != 0) ? win_rr : win_fixed;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_next     = state;
        grant          = 1'b0;
        done_ok        = 1'b0;
        done_to        = 1'b0;
        cnt_inc        = 1'b0;
        bc_valid_req_o = 1'b0;
        m_ready_o      = '0;
        m_err_o        = '0;
        busy_o         = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (!stall_i && (req_vec != '0)) begin
                    grant      = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bc_valid_req_o = 1'b1;
                if (over_hit) begin
                    done_ok    = 1'b1;
                    state_next = S_RESP;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // A real completion takes precedence over an expiring timer.
                if (over_hit) begin
                    done_ok    = 1'b1;
                    state_next = S_RESP;
                end else if ((TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
                    done_to    = 1'b1;
                    state_next = S_RESP;
                end else begin
                    cnt_inc    = 1'b1;
                end
            end
            S_RESP: begin
                m_ready_o  = win_onehot;
                m_err_o    = err_q ? win_onehot : '0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: pending flags, grant capture, timer, response data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= '0;
            rr_ptr    <= IW'(NUM_M - 1);
            winner    <= '0;
            to_cnt    <= '0;
            bc_rw_o   <= 1'b0;
            bc_addr_o <= '0;
            bc_data_o <= '0;
            m_rdata_o <= '0;
            err_q     <= 1'b0;
        end else begin
            // New requests are OR-ed in after the clear so a re-request in
            // the response cycle is not lost.
            pending <= (pending & ~((state == S_RESP) ? win_onehot : '0)) | m_req_i;
            if (grant) begin
                winner    <= win_sel;
                rr_ptr    <= win_sel;
                to_cnt    <= '0;
                bc_rw_o   <= m_rw_i[win_sel];
                bc_addr_o <= m_addr_i[win_sel*AW +: AW];
                bc_data_o <= m_wdata_i[win_sel*DW +: DW];
            end
            if (cnt_inc) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (done_ok || done_to) begin
                err_q <= done_to;
            end
            // Writes leave the shared read line untouched.
            if (done_ok && bc_rw_o) begin
                m_rdata_o <= axi_data_i;
            end else if (done_to) begin
                m_rdata_o <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bus_arbiter_mc
//  Purpose  : Self-checking bench for bus_arbiter_mc. Two instances (fixed
//             priority and round robin, both with a 16-cycle timeout) run
//             against a timestamp-based transaction model; directed vectors,
//             multi-cycle sequences and randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbiter_mc;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TO = 16;
    localparam int NI = 2;      // instance 0: fixed priority, instance 1: round robin
    localparam int NV = 46;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NM-1:0]    req      [NI];
    logic [NM-1:0]    rw       [NI];
    logic [NM*AW-1:0] addr     [NI];
    logic [NM*DW-1:0] wdata    [NI];
    logic             stall    [NI];
    logic [DW-1:0]    axi_data [NI];
    logic             rd_over  [NI];
    logic             wr_over  [NI];
    logic [NM-1:0]    ready    [NI];
    logic [NM-1:0]    err      [NI];
    logic [DW-1:0]    rdata    [NI];
    logic             bc_valid [NI];
    logic             bc_rw    [NI];
    logic [AW-1:0]    bc_addr  [NI];
    logic [DW-1:0]    bc_data  [NI];
    logic             busy     [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bus_arbiter_mc #(
            .NUM_M   (NM),
            .AW      (AW),
            .DW      (DW),
            .RR_MODE (g),
            .TIMEOUT (TO)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .m_req_i        (req[g]),
            .m_rw_i         (rw[g]),
            .m_addr_i       (addr[g]),
            .m_wdata_i      (wdata[g]),
            .m_ready_o      (ready[g]),
            .m_err_o        (err[g]),
            .m_rdata_o      (rdata[g]),
            .stall_i        (stall[g]),
            .bc_valid_req_o (bc_valid[g]),
            .bc_rw_o        (bc_rw[g]),
            .bc_addr_o      (bc_addr[g]),
            .bc_data_o      (bc_data[g]),
            .axi_data_i     (axi_data[g]),
            .axi_rd_over_i  (rd_over[g]),
            .axi_wr_over_i  (wr_over[g]),
            .busy_o         (busy[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int n_print = 0;
    int cyc     = 0;

    task automatic chk(input string name, input int inst, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_print < 40) begin
                $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, inst, cyc, act, exp);
            end
            n_print++;
        end
    endtask

    function automatic int pick(input logic [NM-1:0] v, input bit rr, input int p);
        int k;
        if (!rr) begin
            for (int i = 0; i < NM; i++) if (v[i]) return i;
        end else begin
            for (int j = 1; j <= NM; j++) begin
                k = (p + j) % NM;
                if (v[k]) return k;
            end
        end
        return 0;
    endfunction

    function automatic int oh2i(input logic [NM-1:0] v);
        for (int i = 0; i < NM; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: a transaction is described by its grant cycle, the
    // cycle its response is due, and whether that response is an error.
    // ------------------------------------------------------------------
    bit            known   [NI];
    logic [NM-1:0] m_pend  [NI];
    int            m_ptr   [NI];
    bit            m_act   [NI];
    int            m_win   [NI];
    int            m_gcyc  [NI];
    int            m_rcyc  [NI];
    bit            m_rerr  [NI];
    logic          m_bcrw  [NI];
    logic [AW-1:0] m_bcaddr[NI];
    logic [DW-1:0] m_bcdata[NI];
    logic [DW-1:0] m_rdata [NI];

    initial begin
        for (int d = 0; d < NI; d++) known[d] = 1'b0;
    end

    always @(negedge clk) begin : p_model
        logic [NM-1:0] rv;
        logic [NM-1:0] clr;
        logic [NM-1:0] e_ready;
        bit            ov;
        for (int d = 0; d < NI; d++) begin
            if (known[d]) begin
                e_ready = (m_act[d] && cyc == m_rcyc[d]) ? NM'(1 << m_win[d]) : '0;
                chk("busy",     d, DW'(busy[d]),     DW'(m_act[d]));
                chk("bc_valid", d, DW'(bc_valid[d]), DW'(m_act[d] && cyc == m_gcyc[d] + 1));
                chk("ready",    d, DW'(ready[d]),    DW'(e_ready));
                chk("err",      d, DW'(err[d]),      DW'(m_rerr[d] ? e_ready : '0));
                chk("bc_rw",    d, DW'(bc_rw[d]),    DW'(m_bcrw[d]));
                chk("bc_addr",  d, DW'(bc_addr[d]),  DW'(m_bcaddr[d]));
                chk("bc_data",  d, bc_data[d],       m_bcdata[d]);
                if (e_ready != '0) chk("rdata", d, rdata[d], m_rdata[d]);
            end
            if (!rst_n) begin
                known[d]    = 1'b1;
                m_pend[d]   = '0;
                m_ptr[d]    = NM - 1;
                m_act[d]    = 1'b0;
                m_win[d]    = 0;
                m_gcyc[d]   = -10;
                m_rcyc[d]   = -1;
                m_rerr[d]   = 1'b0;
                m_bcrw[d]   = 1'b0;
                m_bcaddr[d] = '0;
                m_bcdata[d] = '0;
                m_rdata[d]  = '0;
            end else if (known[d]) begin
                clr = '0;
                rv  = m_pend[d] | req[d];
                if (m_act[d] && cyc == m_rcyc[d]) begin
                    m_act[d]      = 1'b0;
                    clr[m_win[d]] = 1'b1;
                end else if (m_act[d] && m_rcyc[d] < 0) begin
                    ov = m_bcrw[d] ? rd_over[d] : wr_over[d];
                    if (ov) begin
                        m_rcyc[d] = cyc + 1;
                        m_rerr[d] = 1'b0;
                        if (m_bcrw[d]) m_rdata[d] = axi_data[d];
                    end else if (cyc == m_gcyc[d] + 1 + TO) begin
                        m_rcyc[d]  = cyc + 1;
                        m_rerr[d]  = 1'b1;
                        m_rdata[d] = '0;
                    end
                end else if (!m_act[d] && !stall[d] && rv != '0) begin
                    m_win[d]    = pick(rv, d == 1, m_ptr[d]);
                    m_act[d]    = 1'b1;
                    m_gcyc[d]   = cyc;
                    m_rcyc[d]   = -1;
                    m_bcrw[d]   = rw[d][m_win[d]];
                    m_bcaddr[d] = addr[d][m_win[d]*AW +: AW];
                    m_bcdata[d] = wdata[d][m_win[d]*DW +: DW];
                    if (d == 1) m_ptr[d] = m_win[d];
                end
                m_pend[d] = (m_pend[d] & ~clr) | req[d];
            end
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Directed vectors (identical inputs on both instances)
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [NM-1:0] req;
        logic [NM-1:0] rw;
        logic          rd;
        logic          wr;
        logic          stall;
        logic          e_valid;
        logic [NM-1:0] e_ready;
        logic [NM-1:0] e_err;
        logic          e_busy;
    } vec_t;

    vec_t tbl [NV];

    initial begin : p_watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        logic [NM-1:0] outst [NI];
        int            got   [NI];
        int            order [NI][6];
        int            exp_rr [6];
        exp_rr = '{0, 1, 2, 0, 1, 2};

        // Table: default idle row, then the rows of each scenario.
        for (int i = 0; i < NV; i++) begin
            tbl[i] = '0;
            tbl[i].rw = 3'b011;          // masters 0/1 read, master 2 writes
        end
        // Single read from master 1, completion 5 cycles after issue
        tbl[0].req = 3'b010;
        tbl[1].e_valid = 1'b1;
        for (int i = 1; i <= 7; i++) tbl[i].e_busy = 1'b1;
        tbl[6].rd = 1'b1;
        tbl[7].e_ready = 3'b010;
        // Simultaneous pulses 0 and 1, completion in the issue cycle
        tbl[8].req = 3'b011;
        tbl[9].e_valid = 1'b1;  tbl[9].rd = 1'b1;  tbl[9].e_busy = 1'b1;
        tbl[10].e_ready = 3'b001; tbl[10].e_busy = 1'b1;
        tbl[12].e_valid = 1'b1; tbl[12].rd = 1'b1; tbl[12].e_busy = 1'b1;
        tbl[13].e_ready = 3'b010; tbl[13].e_busy = 1'b1;
        // Write from master 2 with spurious read completions
        tbl[14].req = 3'b100;
        tbl[15].e_valid = 1'b1; tbl[15].rd = 1'b1;
        tbl[16].rd = 1'b1;
        tbl[17].wr = 1'b1;
        tbl[18].e_ready = 3'b100;
        for (int i = 15; i <= 18; i++) tbl[i].e_busy = 1'b1;
        // Read from master 0 that never completes: 16 WAIT cycles then error
        tbl[19].req = 3'b001;
        tbl[20].e_valid = 1'b1;
        tbl[25].wr = 1'b1;
        for (int i = 20; i <= 37; i++) tbl[i].e_busy = 1'b1;
        tbl[37].e_ready = 3'b001; tbl[37].e_err = 3'b001;
        // Stall with a pending request, release, then a second requester
        tbl[38].req = 3'b010;
        for (int i = 38; i <= 41; i++) tbl[i].stall = 1'b1;
        tbl[43].e_valid = 1'b1;
        for (int i = 43; i <= 45; i++) tbl[i].e_busy = 1'b1;
        tbl[44].req = 3'b100;

        for (int d = 0; d < NI; d++) begin
            req[d] = '0; rw[d] = 3'b011; stall[d] = 1'b0;
            rd_over[d] = 1'b0; wr_over[d] = 1'b0;
            axi_data[d] = {16{8'hA5}};
            addr[d] = {32'h0000_1000, 32'h8000_0040, 32'h0000_0100};
            wdata[d] = {128'h1234, 128'h2222, 128'h1111};
            outst[d] = '0;
        end

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            for (int d = 0; d < NI; d++) begin
                req[d] = tbl[i].req; rw[d] = tbl[i].rw; stall[d] = tbl[i].stall;
                rd_over[d] = tbl[i].rd; wr_over[d] = tbl[i].wr;
            end
            @(negedge clk);
            for (int d = 0; d < NI; d++) begin
                chk("vec_valid", d, DW'(bc_valid[d]), DW'(tbl[i].e_valid));
                chk("vec_ready", d, DW'(ready[d]),    DW'(tbl[i].e_ready));
                chk("vec_err",   d, DW'(err[d]),      DW'(tbl[i].e_err));
                chk("vec_busy",  d, DW'(busy[d]),     DW'(tbl[i].e_busy));
                if (tbl[i].e_ready != '0 && tbl[i].rw[oh2i(tbl[i].e_ready)] && tbl[i].e_err == '0)
                    chk("vec_rdata", d, rdata[d], {16{8'hA5}});
            end
        end

        // Reset in the middle of WAIT with a second request pending
        @(posedge clk); #1;
        for (int d = 0; d < NI; d++) begin
            req[d] = '0; stall[d] = 1'b0; rd_over[d] = 1'b0; wr_over[d] = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < NI; d++) begin
            chk("rst_busy",  d, DW'(busy[d]),     '0);
            chk("rst_valid", d, DW'(bc_valid[d]), '0);
            chk("rst_ready", d, DW'(ready[d]),    '0);
            chk("rst_addr",  d, DW'(bc_addr[d]),  '0);
            chk("rst_rdata", d, rdata[d],         '0);
        end
        repeat (6) begin
            @(negedge clk);
            for (int d = 0; d < NI; d++) chk("rst_no_grant", d, DW'(bc_valid[d]), '0);
        end

        // Held requests from all masters: grant order per instance
        @(posedge clk); #1;
        for (int d = 0; d < NI; d++) begin
            req[d] = 3'b111; rw[d] = 3'b111; rd_over[d] = 1'b1; got[d] = 0;
        end
        for (int c = 0; c < 60 && (got[0] < 6 || got[1] < 6); c++) begin
            @(negedge clk);
            for (int d = 0; d < NI; d++) begin
                if (ready[d] != '0 && got[d] < 6) begin
                    order[d][got[d]] = oh2i(ready[d]);
                    got[d]++;
                end
            end
            @(posedge clk); #1;
        end
        for (int d = 0; d < NI; d++) begin
            chk("hold_count", d, DW'(got[d]), DW'(6));
            for (int k = 0; k < 6 && k < got[d]; k++)
                chk("hold_order", d, DW'(order[d][k]), DW'((d == 1) ? exp_rr[k] : 0));
        end

        // Reset, then randomized traffic on both instances
        for (int d = 0; d < NI; d++) begin
            req[d] = '0; rd_over[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            for (int d = 0; d < NI; d++) begin
                req[d] = '0;
                for (int k = 0; k < NM; k++) begin
                    if (!outst[d][k] && $urandom_range(3) == 0) begin
                        req[d][k]   = 1'b1;
                        outst[d][k] = 1'b1;
                        rw[d][k]    = 1'($urandom_range(1));
                        addr[d][k*AW +: AW]  = $urandom;
                        wdata[d][k*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
                    end
                end
                stall[d]    = ($urandom_range(4) == 0);
                rd_over[d]  = ($urandom_range(5) == 0);
                wr_over[d]  = ($urandom_range(5) == 0);
                axi_data[d] = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            for (int d = 0; d < NI; d++) outst[d] = outst[d] & ~ready[d];
        end

        @(posedge clk); #1;
        for (int d = 0; d < NI; d++) begin
            req[d] = '0; rd_over[d] = 1'b0; wr_over[d] = 1'b0; stall[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
